// File: rtl/vocab_pkg.sv
// Shared types and helpers for the vocabulary SRAM writer.
package vocab_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      WRITE = 3'd2,
      TERM  = 3'd3,
      SEAL  = 3'd4,
      DONE  = 3'd5
   } vocab_wr_state_t;

   localparam logic [63:0] NULL_CHAR = '0;

   // nz[i] is 1 when char i is non-zero; result is the index of the first
   // zero char, or wl when the word fills every slot.
   function automatic int word_len(input logic [31:0] nz, input int wl);
      word_len = wl;
      for (int i = 31; i >= 0; i--) begin
         if (i < wl && !nz[i]) word_len = i;
      end
   endfunction

endpackage

// File: rtl/vocab_addr_ctr.sv
// Write-pointer counter for the vocab SRAM, with the remaining-space compare.
module vocab_addr_ctr #(
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] load_val,
   input  logic                  inc,
   input  logic [ADDR_WIDTH:0]   need,
   output logic [ADDR_WIDTH-1:0] ptr,
   output logic [ADDR_WIDTH-1:0] ptr_nxt,
   output logic                  fits
);

   // Top address is kept free for the end-of-vocabulary marker.
   localparam logic [ADDR_WIDTH:0] LAST_DATA = {1'b0, {ADDR_WIDTH{1'b1}}};

   always_comb begin
      ptr_nxt = ptr;
      if (clr)       ptr_nxt = '0;
      else if (load) ptr_nxt = load_val;
      else if (inc)  ptr_nxt = ptr + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr <= '0;
      else        ptr <= ptr_nxt;
   end

   assign fits = ({1'b0, ptr} + need) <= LAST_DATA;

endmodule

// File: rtl/vocab_writer.sv
// Packs words into the vocab SRAM as NUL-terminated strings, sealed by a marker.
// Optional feature: VOCAB_WRITER_COUNT_EN adds the word_count output.
module vocab_writer
   import vocab_pkg::*;
#(
   parameter int ADDR_WIDTH  = 4,
   parameter int WORD_LENGTH = 3,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [WORD_LENGTH*DATA_WIDTH-1:0] word,
   input  logic                              seal,
   output logic                              mem_cs,
   output logic                              mem_we,
   output logic [ADDR_WIDTH-1:0]             mem_addr,
   output logic [DATA_WIDTH-1:0]             mem_din,
   output logic                              full,
   output logic                              sealed
`ifdef VOCAB_WRITER_COUNT_EN
   ,
   output logic [ADDR_WIDTH-1:0]             word_count
`endif
);

   localparam int CW = $clog2(WORD_LENGTH + 1);

   vocab_wr_state_t                  state, state_d;
   logic [WORD_LENGTH*DATA_WIDTH-1:0] word_q;
   logic [DATA_WIDTH-1:0]            chars [WORD_LENGTH];
   logic [WORD_LENGTH-1:0]           nz;
   logic [CW-1:0]                    n, idx, idx_d;
   logic [ADDR_WIDTH:0]              need;
   logic [ADDR_WIDTH-1:0]            wr_ptr, ptr_nxt;
   logic                             fits, word_ld, full_set, ptr_inc;
   logic                             mem_we_d;
   logic [ADDR_WIDTH-1:0]            mem_addr_d;
   logic [DATA_WIDTH-1:0]            mem_din_d;

   always_comb begin
      for (int i = 0; i < WORD_LENGTH; i++) begin
         chars[i] = word_q[i*DATA_WIDTH +: DATA_WIDTH];
         nz[i]    = |chars[i];
      end
      n = CW'(word_len(32'(nz), WORD_LENGTH));
   end

   assign need = (ADDR_WIDTH+1)'(n) + (ADDR_WIDTH+1)'(1);

   vocab_addr_ctr #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (1'b0),
      .load     (1'b0),
      .load_val ('0),
      .inc      (ptr_inc),
      .need     (need),
      .ptr      (wr_ptr),
      .ptr_nxt  (ptr_nxt),
      .fits     (fits)
   );

   // Handshake: a word transfers on a posedge where in_valid && in_ready;
   // upstream keeps word stable until then, and seal wins over in_valid.
   always_comb begin
      state_d  = state;
      idx_d    = idx;
      word_ld  = 1'b0;
      full_set = 1'b0;
      ptr_inc  = 1'b0;
      case (state)
         IDLE: begin
            if (seal) begin
               state_d = SEAL;
            end else if (in_valid) begin
               word_ld = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (n == '0) begin
               state_d = IDLE;
            end else if (fits) begin
               idx_d   = '0;
               state_d = WRITE;
            end else begin
               full_set = 1'b1;
               state_d  = IDLE;
            end
         end
         WRITE: begin
            ptr_inc = 1'b1;
            if (idx == n - 1'b1) state_d = TERM;
            else                 idx_d   = idx + 1'b1;
         end
         TERM: begin
            ptr_inc = 1'b1;
            state_d = IDLE;
         end
         SEAL:    state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered SRAM port, aligned to the state being entered.
   always_comb begin
      mem_we_d   = 1'b0;
      mem_addr_d = ptr_nxt;
      mem_din_d  = NULL_CHAR[DATA_WIDTH-1:0];
      case (state_d)
         WRITE: begin
            mem_we_d  = 1'b1;
            mem_din_d = chars[idx_d];
         end
         TERM, SEAL: mem_we_d = 1'b1;
         default:    mem_we_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         word_q   <= '0;
         in_ready <= 1'b0;
         mem_cs   <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
         full     <= 1'b0;
         sealed   <= 1'b0;
      end else begin
         state    <= state_d;
         idx      <= idx_d;
         if (word_ld) word_q <= word;
         in_ready <= (state_d == IDLE);
         mem_cs   <= mem_we_d;
         mem_we   <= mem_we_d;
         mem_addr <= mem_addr_d;
         mem_din  <= mem_din_d;
         full     <= full | full_set;
         sealed   <= (state_d == DONE);
      end
   end

`ifdef VOCAB_WRITER_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_count <= '0;
      end else if (state == TERM && word_count != {ADDR_WIDTH{1'b1}}) begin
         word_count <= word_count + 1'b1;
      end
   end
`endif

endmodule

// File: doc/vocab_writer.md
# vocab_writer

Packs fixed-width input words into the vocabulary SRAM as NUL-terminated character strings, one character per address, starting at address 0. It is the write-side counterpart of the vocabulary matcher: it produces the memory image the matcher later scans. An explicit seal request appends an end-of-vocabulary marker and locks the block until reset.

## Interface
- ADDR_WIDTH, 4, vocab SRAM address width; DEPTH = 2**ADDR_WIDTH
- WORD_LENGTH, 3, max characters per input word
- DATA_WIDTH, 8, bits per character
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  word offered
- in_ready  out  1  block can accept a word
- word  in  WORD_LENGTH*DATA_WIDTH  char i in bits [i*DATA_WIDTH +: DATA_WIDTH]; first zero char ends the word
- seal  in  1  request end-of-vocab marker
- mem_cs  out  1  SRAM chip select
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_WIDTH  SRAM address
- mem_din  out  DATA_WIDTH  SRAM write data
- full  out  1  sticky: a word was dropped for lack of space
- sealed  out  1  end marker written; block locked
- word_count  out  ADDR_WIDTH  words stored (only with VOCAB_WRITER_COUNT_EN)

## Operation
- States: IDLE, LOAD, WRITE, TERM, SEAL, DONE.
- IDLE: in_ready=1. If seal=1, go to SEAL; seal has priority over a simultaneous in_valid, which is not accepted. Otherwise, if in_valid=1, latch word, go to LOAD.
- LOAD: n = index of the first zero char, or WORD_LENGTH if none.
  - n=0 (empty word): drop silently, return to IDLE.
  - Fit rule, computed at ADDR_WIDTH+1 bits: wr_ptr+n+1 <= DEPTH-1. The last address is reserved for the seal marker.
  - Fits: go to WRITE with idx=0.
  - Does not fit: set full=1, no writes, return to IDLE.
- WRITE: mem_cs=mem_we=1, mem_addr=wr_ptr, mem_din=char[idx]; wr_ptr++, idx++. After char n-1, go to TERM.
- TERM: write 0 at wr_ptr; wr_ptr++; return to IDLE.
- SEAL: write 0 at wr_ptr. wr_ptr is not incremented. Go to DONE.
- DONE: sealed=1, in_ready=0, seal and in_valid ignored. Only rst_n exits this state.
- full is sticky until reset. Once full is set, later words are still accepted and then dropped unless they fit. Seal is always permitted.
- wr_ptr never wraps; the fit rule guarantees wr_ptr <= DEPTH-1.
- Reset (any time, including mid-word): state=IDLE, wr_ptr=0, in_ready=0 during reset then 1, full=0, sealed=0, mem_cs=mem_we=0, mem_addr=0, mem_din=0, word_count=0. A partially written word is abandoned; memory contents are not cleared.

## Timing
- All outputs are registered. mem_* are valid in the cycle of the write, for an SRAM that captures on posedge.
- Handshake: a word is accepted on the posedge with in_valid && in_ready; upstream holds word until then.
- A word of n chars accepted at edge k:
  - LOAD at cycle k+1
  - char writes at cycles k+2 .. k+1+n
  - terminator write at cycle k+2+n
  - in_ready=1 again at cycle k+3+n
- Dropped word (empty or no fit): in_ready returns at cycle k+2.
- Seal sampled at edge k: marker write at cycle k+1, sealed=1 from cycle k+2.
- mem_we is high for exactly one cycle per written address. No back-to-back word overlap.

## Configuration
- VOCAB_WRITER_COUNT_EN defined: word_count port present; it increments in TERM and saturates at DEPTH-1.
- Not defined: word_count port and register absent; all other behaviour is identical.

## Structure
- Package vocab_pkg holds:
  - the state enum vocab_wr_state_t
  - NULL_CHAR = '0
  - the function that computes the word length n
- One sub-module: vocab_addr_ctr. It is a loadable and clearable ADDR_WIDTH counter with increment enable, providing wr_ptr and the remaining-space compare.

## Test plan
Defaults: DEPTH=16; characters are listed as char0,char1,char2.
- "cat" (word=0x746163) accepted at reset exit -> writes 0x63@0, 0x61@1, 0x74@2, 0x00@3. in_ready returns 6 cycles after acceptance. wr_ptr=4, word_count=1.
- "hi" (0x006968), then "a" (0x000061) -> writes 0x68@0, 0x69@1, 0x00@2, 0x61@3, 0x00@4.
- Empty word (0x000000) -> no mem_we pulse, full=0, in_ready back after 2 cycles.
- Fill with "abc" words (4 addresses each) -> three stored at 0..11. The fourth would need 12..15, violating the fit rule, so full=1 and no writes. Then "z" -> stored at 12,13.
- seal and in_valid asserted in the same cycle -> word not accepted, 0x00 written at wr_ptr, sealed=1. Later in_valid is ignored and in_ready stays 0.
- rst_n asserted during WRITE of "cat" after 0x63@0 -> all outputs return to reset values immediately. After release, "dog" is written starting at address 0.
